// File: rtl/sync_fifo_packer_if.sv
// Handshake bundle between the FIFO read port, the packer and the wide datapath.
// The packer uses the slave view; whatever drives the FIFO side and sinks the wide side uses the master view.
interface sync_fifo_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);
  logic                             i_valid_s;
  logic [DATA_WIDTH-1:0]            i_datain;
  logic                             o_ready_s;
  logic                             i_flush;
  logic                             o_valid_m;
  logic [DATA_WIDTH*PACK_RATIO-1:0] o_dataout;
  logic [PACK_RATIO-1:0]            o_keep;
  logic                             i_ready_m;

  modport slave (
    input  i_valid_s, i_datain, i_flush, i_ready_m,
    output o_ready_s, o_valid_m, o_dataout, o_keep
  );

  modport master (
    output i_valid_s, i_datain, i_flush, i_ready_m,
    input  o_ready_s, o_valid_m, o_dataout, o_keep
  );
endinterface

// File: rtl/sync_fifo_packer.sv
// Packs PACK_RATIO narrow FIFO words into one wide word with per-lane keep flags.
// Define SYNC_FIFO_PACKER_MSB_FIRST_EN to fill lanes from the most significant lane downward.
module sync_fifo_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = $clog2(PACK_RATIO)
) (
  input logic              i_clk,
  input logic              i_rst,
  sync_fifo_packer_if.slave bus
);

  localparam int                   OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(PACK_RATIO - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt, lane;
  logic [OUT_WIDTH-1:0]   asm_data, asm_data_mrg, asm_data_nxt;
  logic [OUT_WIDTH-1:0]   out_data, out_data_nxt;
  logic [PACK_RATIO-1:0]  asm_keep, asm_keep_mrg, asm_keep_nxt;
  logic [PACK_RATIO-1:0]  out_keep, out_keep_nxt;
  logic                   in_acc, out_acc;

  assign bus.o_valid_m = (state == HOLD);
  assign bus.o_ready_s = !i_rst && ((state == FILL) || bus.i_ready_m);
  assign bus.o_dataout = out_data;
  assign bus.o_keep    = out_keep;

  assign in_acc  = bus.i_valid_s & bus.o_ready_s;
  assign out_acc = bus.o_valid_m & bus.i_ready_m;

`ifdef SYNC_FIFO_PACKER_MSB_FIRST_EN
  // PACK_RATIO is a power of two, so ~cnt equals PACK_RATIO-1-cnt.
  assign lane = ~cnt;
`else
  assign lane = cnt;
`endif

  // Assembly contents as they would be with this cycle's accepted word included.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    asm_data_mrg = asm_data;
    asm_keep_mrg = asm_keep;
    if (in_acc) begin
      asm_data_mrg[lane*DATA_WIDTH +: DATA_WIDTH] = bus.i_datain;
      asm_keep_mrg[lane]                          = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    asm_data_nxt = asm_data_mrg;
    asm_keep_nxt = asm_keep_mrg;
    out_data_nxt = out_data;
    out_keep_nxt = out_keep;
    cnt_nxt      = in_acc ? cnt + CNT_WIDTH'(1) : cnt;

    unique case (state)
      FILL: begin
        // Close the word when it is full, or on flush if at least one lane is occupied.
        if ((in_acc && cnt == LAST_CNT) || (bus.i_flush && (cnt != '0 || in_acc))) begin
          out_data_nxt = asm_data_mrg;
          out_keep_nxt = asm_keep_mrg;
          asm_data_nxt = '0;
          asm_keep_nxt = '0;
          cnt_nxt      = '0;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        // A pop here is only possible alongside an output accept; it lands in lane 0 of a fresh word.
        if (out_acc) begin
          out_keep_nxt = '0;
          state_nxt    = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= FILL;
      cnt      <= '0;
      asm_data <= '0;
      asm_keep <= '0;
      out_data <= '0;
      out_keep <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      asm_data <= asm_data_nxt;
      asm_keep <= asm_keep_nxt;
      out_data <= out_data_nxt;
      out_keep <= out_keep_nxt;
    end
  end

endmodule

// File: tb/tb_sync_fifo_packer.sv
// Self-checking bench for sync_fifo_packer: directed scenarios plus random traffic,
// compared each cycle against a queue-based packet model.
module tb_sync_fifo_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

`ifdef SYNC_FIFO_PACKER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
  localparam logic [OW-1:0] E_FULL  = 32'h11223344;
  localparam logic [OW-1:0] E_BP    = 32'h55667788;
  localparam logic [OW-1:0] E_FL2   = 32'hAABB0000;
  localparam logic [R-1:0]  K_FL2   = 4'hC;
  localparam logic [OW-1:0] E_FL3   = 32'hAABBCC00;
  localparam logic [R-1:0]  K_FL3   = 4'hE;
  localparam logic [OW-1:0] E_RST   = 32'h10111213;
  localparam logic [OW-1:0] E_STRM  = 32'h00010203;
`else
  localparam bit MSB_FIRST = 1'b0;
  localparam logic [OW-1:0] E_FULL  = 32'h44332211;
  localparam logic [OW-1:0] E_BP    = 32'h88776655;
  localparam logic [OW-1:0] E_FL2   = 32'h0000BBAA;
  localparam logic [R-1:0]  K_FL2   = 4'h3;
  localparam logic [OW-1:0] E_FL3   = 32'h00CCBBAA;
  localparam logic [R-1:0]  K_FL3   = 4'h7;
  localparam logic [OW-1:0] E_RST   = 32'h13121110;
  localparam logic [OW-1:0] E_STRM  = 32'h03020100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(R)) bus ();

  sync_fifo_packer #(.DATA_WIDTH(DW), .PACK_RATIO(R)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: words popped for the packet in progress, and the word on the output.
  logic [DW-1:0] pend[$];
  bit            m_valid = 1'b0;
  logic [OW-1:0] m_data  = '0;
  logic [R-1:0]  m_keep  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack_pending();
    m_data = '0;
    m_keep = '0;
    for (int j = 0; j < pend.size(); j++) begin
      int ln;
      ln = MSB_FIRST ? R - 1 - j : j;
      m_data[ln*DW +: DW] = pend[j];
      m_keep[ln]          = 1'b1;
    end
    m_valid = 1'b1;
    pend.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model, clock.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit fl, input bit rm);
    bit exp_ready, in_acc, was_valid;
    bus.i_valid_s = v;
    bus.i_datain  = d;
    bus.i_flush   = fl;
    bus.i_ready_m = rm;
    #1;
    exp_ready = m_valid ? rm : 1'b1;
    check("ready", 64'(bus.o_ready_s), 64'(exp_ready));
    check("valid", 64'(bus.o_valid_m), 64'(m_valid));
    check("keep",  64'(bus.o_keep), 64'(m_valid ? m_keep : '0));
    if (m_valid) check("data", 64'(bus.o_dataout), 64'(m_data));

    in_acc    = v && exp_ready;
    was_valid = m_valid;
    if (m_valid && rm) begin
      m_valid = 1'b0;
      m_keep  = '0;
    end
    if (in_acc) pend.push_back(d);
    if (pend.size() == R || (!was_valid && fl && pend.size() > 0)) pack_pending();

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.i_valid_s = 1'b1;
    bus.i_datain  = 8'h5A;
    bus.i_flush   = 1'b0;
    bus.i_ready_m = 1'b1;
    #1;
    check("rst_ready", 64'(bus.o_ready_s), 64'd0);
    check("rst_valid", 64'(bus.o_valid_m), 64'd0);
    check("rst_data",  64'(bus.o_dataout), 64'd0);
    check("rst_keep",  64'(bus.o_keep),    64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_hold", 64'(bus.o_ready_s), 64'd0);
    check("rst_valid_hold", 64'(bus.o_valid_m), 64'd0);
    pend.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    rst           = 1'b0;
    bus.i_valid_s = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Full word with downstream always ready.
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    check("full_valid", 64'(bus.o_valid_m), 64'd1);
    check("full_data",  64'(bus.o_dataout), 64'(E_FULL));
    check("full_keep",  64'(bus.o_keep),    64'hF);
    idle(2);

    // Backpressure holds the word; the 5th word is popped in the cycle the output is accepted.
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    step(1, 8'h55, 0, 0); step(1, 8'h55, 0, 0);
    check("bp_stable", 64'(bus.o_dataout), 64'(E_FULL));
    step(1, 8'h55, 0, 1);
    step(1, 8'h66, 0, 1); step(1, 8'h77, 0, 1); step(1, 8'h88, 0, 1);
    check("bp_data", 64'(bus.o_dataout), 64'(E_BP));
    idle(2);

    // Flush of a partial word, then a flush with nothing pending.
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 0, 1); step(0, 8'h00, 1, 1);
    check("flush_data", 64'(bus.o_dataout), 64'(E_FL2));
    check("flush_keep", 64'(bus.o_keep),    64'(K_FL2));
    idle(1);
    step(0, 8'h00, 1, 1);
    check("empty_flush", 64'(bus.o_valid_m), 64'd0);

    // Flush coincident with an accept.
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 0, 1); step(1, 8'hCC, 1, 1);
    check("flush_acc_data", 64'(bus.o_dataout), 64'(E_FL3));
    check("flush_acc_keep", 64'(bus.o_keep),    64'(K_FL3));
    idle(2);

    // Reset mid-packet discards the partial data.
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1);
    do_reset();
    step(1, 8'h10, 0, 1); step(1, 8'h11, 0, 1); step(1, 8'h12, 0, 1); step(1, 8'h13, 0, 1);
    check("post_rst_data", 64'(bus.o_dataout), 64'(E_RST));
    check("post_rst_keep", 64'(bus.o_keep),    64'hF);
    idle(2);

    // Back-to-back stream: ready must never drop.
    for (int w = 0; w < 12; w++) begin
      step(1, 8'(w), 0, 1);
      if (w == 3) check("stream_first", 64'(bus.o_dataout), 64'(E_STRM));
    end
    idle(2);

    // Random traffic with occasional flushes, backpressure and one reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
